// File: rtl/spram_ctrl.sv
// spram_ctrl: request/response front end and power sequencer for one 16K x 16
// single-port SPRAM macro. It is the only logic driving the macro pins.
//
// Ports:
//   CLK, RST_N           shared clock, asynchronous active-low reset
//   req_valid/req_ready  single-word request handshake (accept on valid && ready)
//   req_we               1 = write, 0 = read
//   req_addr             word address (ADDR_W bits)
//   req_wdata, req_be    write data and byte enables (bit0 -> [7:0], bit1 -> [15:8])
//   rsp_valid, rsp_rdata read response, two cycles after the read is accepted
//   sleep_req            level request for deep sleep
//   pwr_state            0 ACTIVE, 1 LIGHT, 2 DEEP, 3 WAKE
//   ram_*                registered SPRAM pins; ram_q is the macro read data
//
// Optional feature macro: SPRAM_PWR_OFF_EN
//   When defined, DEEP uses shutdown (ram_sd) instead of deep sleep (ram_ds),
//   losing contents, and WAKE lasts two extra cycles to cover power-up.
//   When undefined, ram_sd is tied to 0 and contents are retained in DEEP.

module spram_ctrl #(
  parameter int ADDR_W      = 14,
  parameter int IDLE_CYCLES = 64,
  parameter int WAKE_CYCLES = 2
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [15:0]       req_wdata,
  input  logic [1:0]        req_be,
  output logic              rsp_valid,
  output logic [15:0]       rsp_rdata,
  input  logic              sleep_req,
  output logic [1:0]        pwr_state,
  output logic [ADDR_W-1:0] ram_adr,
  output logic [15:0]       ram_d,
  output logic [15:0]       ram_wem,
  output logic              ram_we,
  output logic              ram_me,
  output logic              ram_ls,
  output logic              ram_ds,
  output logic              ram_sd,
  input  logic [15:0]       ram_q
);

  typedef enum logic [1:0] {
    ST_ACTIVE = 2'd0,
    ST_LIGHT  = 2'd1,
    ST_DEEP   = 2'd2,
    ST_WAKE   = 2'd3
  } pwr_state_t;

`ifdef SPRAM_PWR_OFF_EN
  localparam int WAKE_LEN = WAKE_CYCLES + 2;
`else
  localparam int WAKE_LEN = WAKE_CYCLES;
`endif

  localparam int IDLE_W = (IDLE_CYCLES > 0) ? $clog2(IDLE_CYCLES + 1) : 1;
  localparam int WAKE_W = $clog2(WAKE_LEN + 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(IDLE_CYCLES);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'((IDLE_CYCLES > 0) ? IDLE_CYCLES - 1 : 0);
  localparam logic [WAKE_W-1:0] WAKE_LAST = WAKE_W'(WAKE_LEN - 1);

  pwr_state_t        state;
  pwr_state_t        state_nxt;
  logic [IDLE_W-1:0] idle_cnt;
  logic [WAKE_W-1:0] wake_cnt;
  logic              rd_pend;
  logic              accept;

  assign req_ready = (state == ST_ACTIVE) && !sleep_req;
  assign accept    = req_valid && req_ready;
  assign pwr_state = state;
  assign rsp_rdata = ram_q;

  // Next-state logic. Deep sleep wins over light sleep, and neither is taken
  // while the macro is still busy with an access issued on the previous edge.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_ACTIVE: begin
        if (sleep_req && !ram_me)
          state_nxt = ST_DEEP;
        else if ((IDLE_CYCLES != 0) && (idle_cnt == IDLE_LAST) && !accept && !ram_me)
          state_nxt = ST_LIGHT;
      end
      ST_LIGHT: begin
        if (sleep_req)
          state_nxt = ST_DEEP;
        else if (req_valid)
          state_nxt = ST_WAKE;
      end
      ST_DEEP: begin
        if (!sleep_req)
          state_nxt = ST_WAKE;
      end
      ST_WAKE: begin
        if (wake_cnt == WAKE_LAST)
          state_nxt = ST_ACTIVE;
      end
      default: state_nxt = ST_ACTIVE;
    endcase
  end

  // State register plus idle and wake counters. Both counters sit at zero
  // outside their own state, so they start from zero on every entry.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= ST_ACTIVE;
      idle_cnt <= '0;
      wake_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (accept || (state != ST_ACTIVE))
        idle_cnt <= '0;
      else if (idle_cnt != IDLE_MAX)
        idle_cnt <= idle_cnt + 1'b1;
      if (state != ST_WAKE)
        wake_cnt <= '0;
      else if (wake_cnt != WAKE_LAST)
        wake_cnt <= wake_cnt + 1'b1;
    end
  end

  // Macro pins. Address, data and mask only load on an accept so they stay
  // quiet between accesses; enables pulse for exactly one cycle per request.
  // A read marks rd_pend while the macro samples, then rsp_valid follows.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ram_me    <= 1'b0;
      ram_we    <= 1'b0;
      ram_adr   <= '0;
      ram_d     <= '0;
      ram_wem   <= '0;
      rd_pend   <= 1'b0;
      rsp_valid <= 1'b0;
    end else begin
      ram_me    <= accept;
      ram_we    <= accept && req_we;
      rd_pend   <= accept && !req_we;
      rsp_valid <= rd_pend;
      if (accept) begin
        ram_adr <= req_addr;
        ram_d   <= req_wdata;
        ram_wem <= req_we ? {{8{req_be[1]}}, {8{req_be[0]}}} : 16'h0000;
      end
    end
  end

  // Power pins follow the next state so they switch on the same edge as
  // pwr_state.
`ifdef SPRAM_PWR_OFF_EN
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ram_ls <= 1'b0;
      ram_ds <= 1'b0;
      ram_sd <= 1'b0;
    end else begin
      ram_ls <= (state_nxt == ST_LIGHT);
      ram_ds <= 1'b0;
      ram_sd <= (state_nxt == ST_DEEP);
    end
  end
`else
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ram_ls <= 1'b0;
      ram_ds <= 1'b0;
    end else begin
      ram_ls <= (state_nxt == ST_LIGHT);
      ram_ds <= (state_nxt == ST_DEEP);
    end
  end

  assign ram_sd = 1'b0;
`endif

endmodule

// File: tb/tb_spram_ctrl.sv
// tb_spram_ctrl: self-checking bench for spram_ctrl (default build).
// Contains a simple SPRAM macro model, a cycle-level behavioural model of the
// controller built from timestamps and a golden memory, a per-cycle compare
// process, and directed scenarios with hand-computed expectations.

module tb_spram_ctrl;

  localparam int AW    = 14;
  localparam int IDLE  = 64;
  localparam int WAKE  = 2;

  logic        CLK;
  logic        RST_N;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [13:0] req_addr;
  logic [15:0] req_wdata;
  logic [1:0]  req_be;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        sleep_req;
  logic [1:0]  pwr_state;
  logic [13:0] ram_adr;
  logic [15:0] ram_d;
  logic [15:0] ram_wem;
  logic        ram_we;
  logic        ram_me;
  logic        ram_ls;
  logic        ram_ds;
  logic        ram_sd;
  logic [15:0] ram_q;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 0;
  int cyc = 0;

  spram_ctrl #(.ADDR_W(AW), .IDLE_CYCLES(IDLE), .WAKE_CYCLES(WAKE)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .sleep_req(sleep_req), .pwr_state(pwr_state),
    .ram_adr(ram_adr), .ram_d(ram_d), .ram_wem(ram_wem), .ram_we(ram_we),
    .ram_me(ram_me), .ram_ls(ram_ls), .ram_ds(ram_ds), .ram_sd(ram_sd),
    .ram_q(ram_q)
  );

  // Free-running 100 MHz clock.
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Cycle index used by the model for its timestamps.
  always @(posedge CLK) cyc <= cyc + 1;

  // SPRAM macro model: bit-masked write, registered read data.
  logic [15:0] mem [0:16383];
  logic [15:0] gmem [0:16383];
  initial begin
    for (int i = 0; i < 16384; i++) begin
      mem[i]  = 16'h0000;
      gmem[i] = 16'h0000;
    end
    ram_q = 16'h0000;
  end
  always @(posedge CLK) begin
    if (ram_me) begin
      if (ram_we)
        mem[ram_adr] <= (mem[ram_adr] & ~ram_wem) | (ram_d & ram_wem);
      else
        ram_q <= mem[ram_adr];
    end
  end

  // Behavioural model of the controller. Idle and wake durations are tracked
  // as "cycle where the count restarted" timestamps, read data comes from a
  // golden memory updated byte-wise at accept time.
  int          m_state;
  int          ref_idle;
  int          ref_wake;
  bit          m_me, m_we, m_ls, m_ds;
  logic [13:0] m_adr;
  logic [15:0] m_d, m_wem;
  bit          rd1, rd2;
  logic [15:0] rd1d, rd2d;

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      m_state = 0; ref_idle = cyc + 1; ref_wake = 0;
      m_me = 0; m_we = 0; m_ls = 0; m_ds = 0;
      m_adr = '0; m_d = '0; m_wem = '0;
      rd1 = 0; rd2 = 0; rd1d = '0; rd2d = '0;
    end else begin
      automatic int  c     = cyc;
      automatic bit  ready = (m_state == 0) && !sleep_req;
      automatic bit  acc   = req_valid && ready;
      automatic int  nxt   = m_state;
      case (m_state)
        0: begin
          if (sleep_req && !m_me) nxt = 2;
          else if ((c - ref_idle) == IDLE - 1 && !acc && !m_me) nxt = 1;
        end
        1: nxt = sleep_req ? 2 : (req_valid ? 3 : 1);
        2: nxt = sleep_req ? 2 : 3;
        default: if ((c - ref_wake) == WAKE - 1) nxt = 0;
      endcase
      if (acc) ref_idle = c + 1;
      if (nxt == 0 && m_state != 0) ref_idle = c + 1;
      if (nxt == 3 && m_state != 3) ref_wake = c + 1;
      rd2 = rd1; rd2d = rd1d;
      rd1 = acc && !req_we;
      if (acc && !req_we) rd1d = gmem[req_addr];
      if (acc && req_we) begin
        if (req_be[0]) gmem[req_addr][7:0]  = req_wdata[7:0];
        if (req_be[1]) gmem[req_addr][15:8] = req_wdata[15:8];
      end
      m_me = acc;
      m_we = acc && req_we;
      if (acc) begin
        m_adr = req_addr;
        m_d   = req_wdata;
        m_wem = req_we ? {(req_be[1] ? 8'hFF : 8'h00), (req_be[0] ? 8'hFF : 8'h00)} : 16'h0000;
      end
      m_ls = (nxt == 1);
      m_ds = (nxt == 2);
      m_state = nxt;
    end
  end

  // Single comparison: bumps the counters and reports any difference.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare of every DUT output against the model, mid-cycle.
  always @(negedge CLK) begin
    if (chk_en) begin
      checkOutput("req_ready", 32'(req_ready), 32'((m_state == 0) && !sleep_req));
      checkOutput("pwr_state", 32'(pwr_state), 32'(m_state));
      checkOutput("ram_me",    32'(ram_me),    32'(m_me));
      checkOutput("ram_we",    32'(ram_we),    32'(m_we));
      checkOutput("ram_adr",   32'(ram_adr),   32'(m_adr));
      checkOutput("ram_d",     32'(ram_d),     32'(m_d));
      checkOutput("ram_wem",   32'(ram_wem),   32'(m_wem));
      checkOutput("ram_ls",    32'(ram_ls),    32'(m_ls));
      checkOutput("ram_ds",    32'(ram_ds),    32'(m_ds));
      checkOutput("ram_sd",    32'(ram_sd),    32'd0);
      checkOutput("rsp_valid", 32'(rsp_valid), 32'(rd2));
      if (rd2) checkOutput("rsp_rdata", 32'(rsp_rdata), 32'(rd2d));
    end
  end

  // Log of responses for the back-to-back ordering check.
  logic [15:0] log_d[$];
  int          log_c[$];
  always @(negedge CLK) begin
    if (chk_en && rsp_valid) begin
      log_d.push_back(rsp_rdata);
      log_c.push_back(cyc);
    end
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Drive request inputs.
  task automatic applyStimulus(input bit v, input bit we, input logic [13:0] a,
                               input logic [15:0] d, input logic [1:0] be);
    req_valid = v; req_we = we; req_addr = a; req_wdata = d; req_be = be;
  endtask

  // Present a request and hold it until accepted; returns 1 ns after the
  // accepting edge with req_valid dropped.
  task automatic sendReq(input bit we, input logic [13:0] a, input logic [15:0] d,
                         input logic [1:0] be);
    bit got = 0;
    applyStimulus(1'b1, we, a, d, be);
    for (int i = 0; i < 200; i++) begin
      @(negedge CLK);
      if (req_ready) begin got = 1; break; end
    end
    if (!got) checkOutput("accept_timeout", 32'd0, 32'd1);
    @(posedge CLK); #1;
    req_valid = 1'b0;
  endtask

  // Read an address and check the response two cycles after the accept.
  task automatic readCheck(input string name, input logic [13:0] a, input logic [15:0] exp);
    sendReq(1'b0, a, 16'h0000, 2'b11);
    @(negedge CLK);
    @(negedge CLK);
    checkOutput({name, "_valid"}, 32'(rsp_valid), 32'd1);
    checkOutput(name, 32'(rsp_rdata), 32'(exp));
  endtask

  initial begin
    RST_N = 1'b0; sleep_req = 1'b0;
    applyStimulus(1'b0, 1'b0, '0, '0, 2'b00);
    @(posedge CLK); #1;
    chk_en = 1;

    // Reset state
    repeat (2) @(negedge CLK);
    checkOutput("rst_ready",  32'(req_ready), 32'd1);
    checkOutput("rst_pwr",    32'(pwr_state), 32'd0);
    checkOutput("rst_me",     32'(ram_me),    32'd0);
    checkOutput("rst_rspv",   32'(rsp_valid), 32'd0);
    sleep_req = 1'b1; #1;
    checkOutput("rst_ready_sleep", 32'(req_ready), 32'd0);
    sleep_req = 1'b0;
    @(posedge CLK); #1;
    RST_N = 1'b1;

    // Basic read-back
    sendReq(1'b1, 14'h0010, 16'hA5C3, 2'b11);
    readCheck("basic", 14'h0010, 16'hA5C3);

    // Byte masking, including a zero-mask write that must change nothing
    sendReq(1'b1, 14'h3FFF, 16'hFFFF, 2'b11);
    sendReq(1'b1, 14'h3FFF, 16'h0000, 2'b01);
    sendReq(1'b1, 14'h3FFF, 16'h0000, 2'b00);
    readCheck("mask", 14'h3FFF, 16'hFF00);

    // Back-to-back reads of preloaded words
    for (int i = 0; i < 8; i++) sendReq(1'b1, 14'(i), 16'(i), 2'b11);
    log_d.delete(); log_c.delete();
    for (int i = 0; i < 8; i++) sendReq(1'b0, 14'(i), 16'h0000, 2'b11);

    // Auto light sleep after 64 idle cycles
    repeat (63) @(negedge CLK);
    checkOutput("idle63_pwr", 32'(pwr_state), 32'd0);
    @(negedge CLK);
    checkOutput("idle64_pwr", 32'(pwr_state), 32'd0);
    @(negedge CLK);
    checkOutput("light_pwr", 32'(pwr_state), 32'd1);
    checkOutput("light_ls",  32'(ram_ls),    32'd1);

    checkOutput("b2b_count", 32'(log_d.size()), 32'd8);
    for (int i = 0; i < 8 && i < log_d.size(); i++) begin
      checkOutput("b2b_data", 32'(log_d[i]), 32'(i));
      checkOutput("b2b_cycle", 32'(log_c[i] - log_c[0]), 32'(i));
    end

    // Wake from light sleep with a pending read of address 5
    @(posedge CLK); #1;
    applyStimulus(1'b1, 1'b0, 14'h0005, 16'h0000, 2'b11);
    @(negedge CLK);
    checkOutput("wake_m_ready", 32'(req_ready), 32'd0);
    @(negedge CLK);
    checkOutput("wake_m1_ls",   32'(ram_ls),    32'd0);
    checkOutput("wake_m1_pwr",  32'(pwr_state), 32'd3);
    @(negedge CLK);
    checkOutput("wake_m2_ready", 32'(req_ready), 32'd0);
    @(negedge CLK);
    checkOutput("wake_m3_ready", 32'(req_ready), 32'd1);
    @(posedge CLK); #1;
    req_valid = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    checkOutput("wake_rd_valid", 32'(rsp_valid), 32'd1);
    checkOutput("wake_rd_data",  32'(rsp_rdata), 32'h0005);

    // Deep sleep requested the cycle after a read accept
    sendReq(1'b1, 14'h0100, 16'h1234, 2'b11);
    sendReq(1'b0, 14'h0100, 16'h0000, 2'b11);
    sleep_req = 1'b1;
    @(negedge CLK);
    checkOutput("deep_ready", 32'(req_ready), 32'd0);
    @(negedge CLK);
    checkOutput("deep_rspv", 32'(rsp_valid), 32'd1);
    checkOutput("deep_rspd", 32'(rsp_rdata), 32'h1234);
    @(negedge CLK);
    checkOutput("deep_pwr",  32'(pwr_state), 32'd2);
    checkOutput("deep_ds",   32'(ram_ds),    32'd1);
    repeat (5) @(negedge CLK);
    @(posedge CLK); #1;
    sleep_req = 1'b0;
    @(negedge CLK);
    checkOutput("deep_hold_pwr", 32'(pwr_state), 32'd2);
    @(negedge CLK);
    checkOutput("deep_wake_pwr", 32'(pwr_state), 32'd3);
    checkOutput("deep_wake_ds",  32'(ram_ds),    32'd0);
    readCheck("deep_retain", 14'h0100, 16'h1234);
    readCheck("deep_retain2", 14'h0010, 16'hA5C3);

    // Reset in the cycle after a read accept drops the response
    sendReq(1'b0, 14'h0010, 16'h0000, 2'b11);
    RST_N = 1'b0; #1;
    checkOutput("rstmid_me",   32'(ram_me),    32'd0);
    checkOutput("rstmid_adr",  32'(ram_adr),   32'd0);
    checkOutput("rstmid_rspv", 32'(rsp_valid), 32'd0);
    @(negedge CLK);
    checkOutput("rstmid_rspv1", 32'(rsp_valid), 32'd0);
    @(negedge CLK);
    checkOutput("rstmid_rspv2", 32'(rsp_valid), 32'd0);
    @(posedge CLK); #1;
    RST_N = 1'b1;
    @(negedge CLK);
    checkOutput("rstrel_ready", 32'(req_ready), 32'd1);
    checkOutput("rstrel_pwr",   32'(pwr_state), 32'd0);
    readCheck("rstrel_read", 14'h0010, 16'hA5C3);

    repeat (3) @(negedge CLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
